// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: the matrix side (row_n in, col_n out) and the
// key-report side that feeds the calculator core.
interface keypad_scanner_if;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_pressed;
    logic [24:0] keypad_out;
    logic        key_strobe;

    // The scanner drives the columns and the key report, and reads the rows
    modport master (
        input  row_n,
        output col_n,
        output key_pressed,
        output keypad_out,
        output key_strobe
    );

    // The keypad/consumer side drives the rows and reads everything else
    modport slave (
        output row_n,
        input  col_n,
        input  key_pressed,
        input  keypad_out,
        input  key_strobe
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with row synchroniser, press/release
// debounce and key-code mapping for the fixed-point calculator core.
// A key is accepted only when exactly one row is low on the driven column.
// While a key is held, the column is frozen, so other keys cannot be reported.
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  bus
);

    localparam int SETTLE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]    DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    state_t                state;
    logic [3:0]            row_meta;
    logic [3:0]            rows_s;
    logic [1:0]            col_idx;
    logic [1:0]            next_col;
    logic [3:0]            col_n_q;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [DEB_W-1:0]      deb_cnt;
    logic [3:0]            lat_pat;
    logic [1:0]            lat_row;
    logic                  key_pressed_q;
    logic [3:0]            code_q;
    logic                  key_strobe_q;

    // True when exactly one row line is pulled low
    function automatic logic one_low(input logic [3:0] pat);
        logic result;
        case (pat)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: result = 1'b1;
            default:                            result = 1'b0;
        endcase
        return result;
    endfunction

    // Row index of a one-hot-zero row pattern
    function automatic logic [1:0] row_of(input logic [3:0] pat);
        logic [1:0] result;
        case (pat)
            4'b1101: result = 2'd1;
            4'b1011: result = 2'd2;
            4'b0111: result = 2'd3;
            default: result = 2'd0;
        endcase
        return result;
    endfunction

    // Active-low one-hot-zero column drive for a column index
    function automatic logic [3:0] col_drive(input logic [1:0] c);
        logic [3:0] result;
        case (c)
            2'd0:    result = 4'b1110;
            2'd1:    result = 4'b1101;
            2'd2:    result = 4'b1011;
            default: result = 4'b0111;
        endcase
        return result;
    endfunction

    // Keypad legend: A=plus, B=minus, C=multiply, E=clear, F=decimal point
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] result;
        case ({r, c})
            4'b00_00: result = 4'h1;
            4'b00_01: result = 4'h2;
            4'b00_10: result = 4'h3;
            4'b00_11: result = 4'hA;
            4'b01_00: result = 4'h4;
            4'b01_01: result = 4'h5;
            4'b01_10: result = 4'h6;
            4'b01_11: result = 4'hB;
            4'b10_00: result = 4'h7;
            4'b10_01: result = 4'h8;
            4'b10_10: result = 4'h9;
            4'b10_11: result = 4'hC;
            4'b11_00: result = 4'hF;
            4'b11_01: result = 4'h0;
            4'b11_10: result = 4'hE;
            default:  result = 4'hD;
        endcase
        return result;
    endfunction

    assign next_col = col_idx + 2'd1;

    // Two-flop synchroniser for the asynchronous row lines; idles at "no key"
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta <= 4'hF;
            rows_s   <= 4'hF;
        end else begin
            row_meta <= bus.row_n;
            rows_s   <= row_meta;
        end
    end

    // Scan / debounce / hold / release state machine with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_SCAN;
            col_idx       <= 2'd0;
            col_n_q       <= 4'b1110;
            settle_cnt    <= '0;
            deb_cnt       <= '0;
            lat_pat       <= 4'hF;
            lat_row       <= 2'd0;
            key_pressed_q <= 1'b0;
            code_q        <= 4'h0;
            key_strobe_q  <= 1'b0;
        end else begin
            key_strobe_q <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        if (one_low(rows_s)) begin
                            lat_pat <= rows_s;
                            lat_row <= row_of(rows_s);
                            deb_cnt <= '0;
                            state   <= ST_DEBOUNCE;
                        end else begin
                            col_idx <= next_col;
                            col_n_q <= col_drive(next_col);
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                ST_DEBOUNCE: begin
                    if (rows_s == lat_pat) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_cnt       <= '0;
                            code_q        <= key_code(lat_row, col_idx);
                            key_pressed_q <= 1'b1;
                            key_strobe_q  <= 1'b1;
                            state         <= ST_PRESSED;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        deb_cnt    <= '0;
                        settle_cnt <= '0;
                        col_idx    <= next_col;
                        col_n_q    <= col_drive(next_col);
                        state      <= ST_SCAN;
                    end
                end

                ST_PRESSED: begin
                    if (rows_s == 4'hF) begin
                        deb_cnt <= '0;
                        state   <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (rows_s == 4'hF) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_cnt       <= '0;
                            settle_cnt    <= '0;
                            key_pressed_q <= 1'b0;
                            col_idx       <= next_col;
                            col_n_q       <= col_drive(next_col);
                            state         <= ST_SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        deb_cnt <= '0;
                        state   <= ST_PRESSED;
                    end
                end

                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

    assign bus.col_n       = col_n_q;
    assign bus.key_pressed = key_pressed_q;
    assign bus.keypad_out  = {21'd0, code_q};
    assign bus.key_strobe  = key_strobe_q;

endmodule
